// File: rtl/svec_vme_top.sv
// VME64x slave front-end for the SVEC carrier.
// Terminates VME single-cycle transfers, serves the CR/CSR configuration
// space and bridges D32 accesses that hit one of two programmable
// address-space functions onto a Wishbone master port.
module svec_vme_top #(
  parameter logic [31:0] g_f0_mask    = 32'hFF000000,
  parameter logic [31:0] g_f1_mask    = 32'h00C00000,
  parameter int          g_wb_timeout = 256
) (
  input  logic        clk_i,
  input  logic        rst_a_i,
  input  logic        vme_as_n_i,
  input  logic [1:0]  vme_ds_n_i,
  input  logic        vme_write_n_i,
  input  logic        vme_lword_n_i,
  input  logic [5:0]  vme_am_i,
  input  logic [31:1] vme_addr_i,
  input  logic [31:0] vme_data_i,
  input  logic [4:0]  vme_ga_n_i,
  output logic [31:0] vme_data_o,
  output logic        vme_data_oe_o,
  output logic        vme_dtack_n_o,
  output logic        vme_dtack_oe_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [21:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        module_en_o
);

  localparam int CNT_W = $clog2(g_wb_timeout + 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    CSR,
    WB_WAIT,
    DTACK,
    WAIT_DS_HIGH,
    WAIT_AS_HIGH
  } state_t;

  state_t state_reg, state_next;

  logic        as_n_s1_reg, as_n_s2_reg;
  logic [1:0]  ds_n_s1_reg, ds_n_s2_reg;
  logic [31:1] addr_reg;
  logic [5:0]  am_reg;
  logic        write_n_reg;
  logic        lword_n_reg;
  logic [1:0]  ds_n_reg;
  logic [31:0] wdata_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]  bit_reg;
  logic [7:0]  user_cfg_reg;
  logic [7:0]  csr_rdata;

  logic [1:0][31:0] ader_all;
  logic [1:0]       fn_hit;

  logic        as_act, ds_act;
  logic [31:0] byte_addr;
  logic [18:0] csr_off;
  logic        csr_hit, d32, timeout;
  logic        csr_wr, csr_rd;

  assign as_act    = ~as_n_s2_reg;
  assign ds_act    = (ds_n_s2_reg != 2'b11);
  // An odd byte (DS0 only) carries A0 = 1; D32 and even bytes carry A0 = 0.
  assign byte_addr = {addr_reg, (ds_n_reg == 2'b10)};
  assign csr_off   = byte_addr[18:0];
  assign csr_hit   = (am_reg == 6'h2F) && (addr_reg[23:19] == ~vme_ga_n_i) &&
                     (ds_n_reg == 2'b10);
  assign d32       = ~lword_n_reg && (ds_n_reg == 2'b00) && ~addr_reg[1];
  assign timeout   = (cnt_reg == CNT_W'(g_wb_timeout - 1));
  // A register access only takes effect if the master still holds AS.
  assign csr_wr    = (state_reg == CSR) && as_act && ~write_n_reg;
  assign csr_rd    = (state_reg == CSR) && as_act && write_n_reg;

  assign module_en_o = bit_reg[4];
  assign wb_sel_o    = 4'hF;
  assign wb_adr_o    = addr_reg[23:2];
  assign wb_dat_o    = wdata_reg;

  function automatic logic [7:0] ader_byte(input logic [31:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    ader_byte = v[31:24];
      2'd1:    ader_byte = v[23:16];
      2'd2:    ader_byte = v[15:8];
      default: ader_byte = v[7:0];
    endcase
  endfunction

  // Per-function ADER register and address/AM decoder.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fn
    localparam logic [31:0] MASK      = (gi == 0) ? g_f0_mask : (g_f1_mask & 32'h00FFFFFF);
    localparam logic [14:0] ADER_PAGE = 15'h7FF6 + 15'(gi);

    logic [31:0] ader_reg;
    logic        ader_sel;

    assign ader_sel = csr_wr && (csr_off[18:4] == ADER_PAGE) && (csr_off[1:0] == 2'b11);

    // ADER byte writes; reset value keeps the function disabled (bit 0 set).
    always_ff @(posedge clk_i or posedge rst_a_i) begin
      if (rst_a_i) begin
        ader_reg <= 32'h00000001;
      end else if (ader_sel) begin
        case (csr_off[3:2])
          2'd0:    ader_reg[31:24] <= wdata_reg[7:0];
          2'd1:    ader_reg[23:16] <= wdata_reg[7:0];
          2'd2:    ader_reg[15:8]  <= wdata_reg[7:0];
          default: ader_reg[7:0]   <= wdata_reg[7:0];
        endcase
      end
    end

    assign ader_all[gi] = ader_reg;
    assign fn_hit[gi]   = bit_reg[4] && ~ader_reg[0] && (am_reg == ader_reg[7:2]) &&
                          ((byte_addr & MASK) == (ader_reg & MASK)) && d32;
  end

  // Two-stage synchronisers for the VME strobes.
  always_ff @(posedge clk_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      as_n_s1_reg <= 1'b1;
      as_n_s2_reg <= 1'b1;
      ds_n_s1_reg <= 2'b11;
      ds_n_s2_reg <= 2'b11;
    end else begin
      as_n_s1_reg <= vme_as_n_i;
      as_n_s2_reg <= as_n_s1_reg;
      ds_n_s1_reg <= vme_ds_n_i;
      ds_n_s2_reg <= ds_n_s1_reg;
    end
  end

  // Capture the transfer attributes once the synchronised DS is active.
  always_ff @(posedge clk_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      addr_reg    <= '0;
      am_reg      <= '0;
      write_n_reg <= 1'b1;
      lword_n_reg <= 1'b1;
      ds_n_reg    <= 2'b11;
      wdata_reg   <= '0;
    end else if (state_reg == IDLE && as_act && ds_act) begin
      addr_reg    <= vme_addr_i;
      am_reg      <= vme_am_i;
      write_n_reg <= vme_write_n_i;
      lword_n_reg <= vme_lword_n_i;
      ds_n_reg    <= ds_n_s2_reg;
      wdata_reg   <= vme_data_i;
    end
  end

  // Wishbone watchdog: counts cycles spent waiting for ack.
  always_ff @(posedge clk_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      cnt_reg <= '0;
    end else if (state_reg == DECODE) begin
      cnt_reg <= '0;
    end else if (state_reg == WB_WAIT && !timeout) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Read data register: CSR byte, Wishbone data, or all-ones on timeout.
  always_ff @(posedge clk_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      vme_data_o <= '0;
    end else if (csr_rd) begin
      vme_data_o <= {24'h000000, csr_rdata};
    end else if (state_reg == WB_WAIT && write_n_reg) begin
      if (wb_ack_i) begin
        vme_data_o <= wb_dat_i;
      end else if (timeout) begin
        vme_data_o <= 32'hFFFFFFFF;
      end
    end
  end

  // BIT_SET/BIT_CLR share one register; USER_CFG is a plain byte.
  always_ff @(posedge clk_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      bit_reg      <= '0;
      user_cfg_reg <= '0;
    end else if (csr_wr) begin
      if (csr_off == 19'h7FFFB) bit_reg <= bit_reg | wdata_reg[7:0];
      if (csr_off == 19'h7FFF7) bit_reg <= bit_reg & ~wdata_reg[7:0];
      if (csr_off == 19'h7FF33) user_cfg_reg <= wdata_reg[7:0];
    end
  end

  // CR/CSR read multiplexer; unmapped offsets read as zero.
  always_comb begin
    csr_rdata = 8'h00;
    case (csr_off)
      19'h7FFFB, 19'h7FFF7: csr_rdata = bit_reg;
      19'h7FF33:            csr_rdata = user_cfg_reg;
      19'h0001F:            csr_rdata = 8'h43;
      19'h00023:            csr_rdata = 8'h52;
      default:              csr_rdata = 8'h00;
    endcase
    for (int f = 0; f < 2; f++) begin
      if (csr_off[18:4] == (15'h7FF6 + 15'(f)) && csr_off[1:0] == 2'b11) begin
        csr_rdata = ader_byte(ader_all[f], csr_off[3:2]);
      end
    end
  end

  // State register; reset releases every bus driver at once.
  always_ff @(posedge clk_i or posedge rst_a_i) begin
    if (rst_a_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and bus driver decode.
  always_comb begin
    state_next     = state_reg;
    wb_cyc_o       = 1'b0;
    wb_stb_o       = 1'b0;
    wb_we_o        = 1'b0;
    vme_dtack_n_o  = 1'b1;
    vme_dtack_oe_o = 1'b0;
    vme_data_oe_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (as_act && ds_act) state_next = DECODE;
      end
      DECODE: begin
        if (!as_act)      state_next = IDLE;
        else if (csr_hit) state_next = CSR;
        else if (|fn_hit) state_next = WB_WAIT;
        else              state_next = WAIT_AS_HIGH;
      end
      CSR: begin
        state_next = as_act ? DTACK : IDLE;
      end
      WB_WAIT: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = ~write_n_reg;
        if (!as_act)                  state_next = IDLE;
        else if (wb_ack_i || timeout) state_next = DTACK;
      end
      DTACK: begin
        vme_dtack_n_o  = 1'b0;
        vme_dtack_oe_o = 1'b1;
        vme_data_oe_o  = write_n_reg;
        state_next     = WAIT_DS_HIGH;
      end
      WAIT_DS_HIGH: begin
        vme_dtack_n_o  = 1'b0;
        vme_dtack_oe_o = 1'b1;
        vme_data_oe_o  = write_n_reg;
        if (!ds_act) state_next = IDLE;
      end
      WAIT_AS_HIGH: begin
        if (!as_act) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_svec_vme_top.sv
// Directed + randomized bench for svec_vme_top with a behavioural model of
// the CSR contents and the function decoders, plus a Wishbone slave stub.
module tb_svec_vme_top;

  localparam logic [31:0] F0_MASK = 32'hFF000000;
  localparam logic [31:0] F1_MASK = 32'h00C00000;
  localparam int          TIMEOUT = 256;

  logic        clk_i = 1'b0;
  logic        rst_a_i;
  logic        vme_as_n_i;
  logic [1:0]  vme_ds_n_i;
  logic        vme_write_n_i;
  logic        vme_lword_n_i;
  logic [5:0]  vme_am_i;
  logic [31:1] vme_addr_i;
  logic [31:0] vme_data_i;
  logic [4:0]  vme_ga_n_i;
  logic [31:0] vme_data_o;
  logic        vme_data_oe_o;
  logic        vme_dtack_n_o;
  logic        vme_dtack_oe_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [21:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        module_en_o;

  svec_vme_top #(
    .g_f0_mask(F0_MASK), .g_f1_mask(F1_MASK), .g_wb_timeout(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_a_i(rst_a_i),
    .vme_as_n_i(vme_as_n_i), .vme_ds_n_i(vme_ds_n_i),
    .vme_write_n_i(vme_write_n_i), .vme_lword_n_i(vme_lword_n_i),
    .vme_am_i(vme_am_i), .vme_addr_i(vme_addr_i), .vme_data_i(vme_data_i),
    .vme_ga_n_i(vme_ga_n_i), .vme_data_o(vme_data_o), .vme_data_oe_o(vme_data_oe_o),
    .vme_dtack_n_o(vme_dtack_n_o), .vme_dtack_oe_o(vme_dtack_oe_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .module_en_o(module_en_o)
  );

  always #4 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Reference model of the configuration space.
  logic [7:0]  m_bits;
  logic [7:0]  m_user;
  logic [31:0] m_ader [2];
  logic [4:0]  csr_slot;

  // Wishbone slave stub state.
  int          ack_delay = 0;
  logic [31:0] slave_rdata = '0;
  int          wait_cnt = 0;
  int          n_acks = 0;
  int          cyc_cycles = 0;
  logic [21:0] last_adr = '0;
  logic        last_we = 1'b0;
  logic [31:0] last_dat = '0;

  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
  end

  // Slave acks after ack_delay cycles of stb, capturing the request.
  always @(negedge clk_i) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (wait_cnt >= ack_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = slave_rdata;
        last_adr = wb_adr_o;
        last_we  = wb_we_o;
        last_dat = wb_dat_o;
        n_acks++;
      end else begin
        wait_cnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(posedge clk_i) if (wb_cyc_o) cyc_cycles++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_hit(input int f, input logic [31:0] a, input logic [5:0] am);
    logic [31:0] mask;
    mask = (f == 0) ? F0_MASK : (F1_MASK & 32'h00FFFFFF);
    return m_bits[4] && !m_ader[f][0] && (am == m_ader[f][7:2]) &&
           (((a ^ m_ader[f]) & mask) == 32'h0);
  endfunction

  // One VME single-cycle transfer; waits at most 'bound' clocks for DTACK.
  task automatic vme_cycle(input logic [31:0] badr, input logic [5:0] am, input logic [1:0] ds,
                           input logic lw_n, input bit wr, input logic [31:0] wd, input int bound,
                           output bit ack, output logic [31:0] rd, output logic oe,
                           output int lat, output int rel);
    @(negedge clk_i);
    vme_addr_i    = badr[31:1];
    vme_am_i      = am;
    vme_write_n_i = !wr;
    vme_lword_n_i = lw_n;
    vme_data_i    = wd;
    vme_as_n_i    = 1'b0;
    @(negedge clk_i);
    vme_ds_n_i = ds;
    lat = 0; ack = 0; rd = '0; oe = 1'b0; rel = 0;
    while (!ack && lat < bound) begin
      @(negedge clk_i);
      lat++;
      if (vme_dtack_n_o == 1'b0 && vme_dtack_oe_o == 1'b1) begin
        ack = 1;
        rd  = vme_data_o;
        oe  = vme_data_oe_o;
      end
    end
    vme_ds_n_i = 2'b11;
    if (ack) begin
      while (vme_dtack_oe_o && rel < 10) begin
        @(negedge clk_i);
        rel++;
      end
    end
    vme_as_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    $display("[TB] vme %s a=%h am=%h ds=%b dtack=%0d lat=%0d data=%h",
             wr ? "wr" : "rd", badr, am, ds, ack, lat, wr ? wd : rd);
  endtask

  task automatic csr_access(input logic [18:0] off, input bit wr, input logic [7:0] wv,
                            output bit ack, output logic [7:0] rv, output int lat);
    logic [31:0] badr, rd;
    logic oe;
    int rel;
    badr = {8'($urandom), csr_slot, off};
    vme_cycle(badr, 6'h2F, 2'b10, 1'b1, wr, {24'($urandom), wv}, 40, ack, rd, oe, lat, rel);
    rv = rd[7:0];
  endtask

  task automatic csr_write(input logic [18:0] off, input logic [7:0] v, input string tag);
    bit ack; logic [7:0] rv; int lat;
    csr_access(off, 1'b1, v, ack, rv, lat);
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
  endtask

  task automatic csr_read(input logic [18:0] off, input logic [7:0] exp, input string tag);
    bit ack; logic [7:0] rv; int lat;
    csr_access(off, 1'b0, 8'h00, ack, rv, lat);
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_val"}, 32'(rv), 32'(exp));
  endtask

  // Function-space access checked against the model's decode rules.
  task automatic fn_access(input logic [31:0] a, input logic [5:0] am, input bit wr,
                           input logic [31:0] wd, input logic lw_n, input logic [1:0] ds,
                           input string tag);
    bit ack, hit, timed_out;
    logic [31:0] rd;
    logic oe;
    int lat, rel, c0, n0, exp_lat;
    hit = (lw_n == 1'b0) && (ds == 2'b00) && (a[1] == 1'b0) &&
          (exp_hit(0, a, am) || exp_hit(1, a, am));
    c0 = cyc_cycles;
    n0 = n_acks;
    vme_cycle(a, am, ds, lw_n, wr, wd, TIMEOUT + 40, ack, rd, oe, lat, rel);
    chk({tag, "_dtack"}, 32'(ack), 32'(hit));
    if (hit) begin
      timed_out = (ack_delay >= TIMEOUT);
      exp_lat   = timed_out ? 4 + TIMEOUT : 5 + ack_delay;
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_oe"}, 32'(oe), 32'(!wr));
      chk({tag, "_rel"}, 32'(rel <= 3), 32'd1);
      if (!timed_out) begin
        chk({tag, "_nack"}, 32'(n_acks - n0), 32'd1);
        chk({tag, "_adr"}, 32'(last_adr), 32'(a[23:2]));
        chk({tag, "_we"}, 32'(last_we), 32'(wr));
        if (wr) chk({tag, "_wdat"}, last_dat, wd);
        else    chk({tag, "_rdat"}, rd, slave_rdata);
      end else if (!wr) begin
        chk({tag, "_tmo_rdat"}, rd, 32'hFFFFFFFF);
      end
    end else begin
      chk({tag, "_nocyc"}, 32'(cyc_cycles - c0), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a, badr;
    logic [7:0]  v, f0_base;
    logic [5:0]  am;
    bit          wr, ack;
    logic [7:0]  rv;
    int          lat;

    rst_a_i       = 1'b1;
    vme_as_n_i    = 1'b1;
    vme_ds_n_i    = 2'b11;
    vme_write_n_i = 1'b1;
    vme_lword_n_i = 1'b1;
    vme_am_i      = '0;
    vme_addr_i    = '0;
    vme_data_i    = '0;
    vme_ga_n_i    = ~5'd8;
    csr_slot      = 5'd8;
    m_bits = '0; m_user = '0; m_ader[0] = 32'h1; m_ader[1] = 32'h1;
    repeat (3) @(negedge clk_i);

    chk("rst_dtack_n", 32'(vme_dtack_n_o), 32'd1);
    chk("rst_dtack_oe", 32'(vme_dtack_oe_o), 32'd0);
    chk("rst_data_oe", 32'(vme_data_oe_o), 32'd0);
    chk("rst_data", vme_data_o, 32'h0);
    chk("rst_wb_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    chk("rst_en", 32'(module_en_o), 32'd0);
    chk("wb_sel", 32'(wb_sel_o), 32'hF);
    rst_a_i = 1'b0;
    @(negedge clk_i);

    // Configuration ROM signature and reset contents.
    csr_read(19'h0001F, 8'h43, "cr_c");
    csr_read(19'h00023, 8'h52, "cr_r");
    csr_read(19'h7FF7F, 8'h01, "ader1_rst");
    csr_read(19'h7FF6F, 8'h01, "ader0_rst");
    csr_read(19'h7FFFB, 8'h00, "bitset_rst");
    csr_read(19'h7FF33, 8'h00, "user_rst");

    // ADER1 = 0x00C000E4: A24 base 0xC00000, AM 0x39.
    csr_write(19'h7FF73, 8'h00, "ader1_b3_wr");
    csr_write(19'h7FF77, 8'hC0, "ader1_b2_wr");
    csr_write(19'h7FF7B, 8'h00, "ader1_b1_wr");
    csr_write(19'h7FF7F, 8'hE4, "ader1_b0_wr");
    m_ader[1] = 32'h00C000E4;
    csr_read(19'h7FF73, m_ader[1][31:24], "ader1_b3");
    csr_read(19'h7FF77, m_ader[1][23:16], "ader1_b2");
    csr_read(19'h7FF7B, m_ader[1][15:8], "ader1_b1");
    csr_read(19'h7FF7F, m_ader[1][7:0], "ader1_b0");

    m_user = 8'($urandom);
    csr_write(19'h7FF33, m_user, "user_wr");
    csr_read(19'h7FF33, m_user, "user");
    csr_write(19'h7FF01, 8'($urandom), "unmapped_wr");
    csr_read(19'h7FF01, 8'h00, "unmapped");

    csr_write(19'h7FFFB, 8'h10, "bitset_wr");
    m_bits = m_bits | 8'h10;
    chk("en_set", 32'(module_en_o), 32'd1);
    csr_write(19'h7FFF7, 8'h10, "bitclr_wr");
    m_bits = m_bits & ~8'h10;
    chk("en_clr", 32'(module_en_o), 32'd0);

    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        csr_write(19'h7FFFB, v, "rbit_set");
        m_bits = m_bits | v;
      end else begin
        csr_write(19'h7FFF7, v, "rbit_clr");
        m_bits = m_bits & ~v;
      end
      chk("rbit_en", 32'(module_en_o), 32'(m_bits[4]));
      csr_read(19'h7FFF7, m_bits, "rbit_rd");
    end

    csr_write(19'h7FFFB, 8'h10, "enable");
    m_bits = m_bits | 8'h10;

    // Function 0: A32 window at a random top byte, AM 0x09.
    f0_base = 8'($urandom);
    csr_write(19'h7FF63, f0_base, "ader0_b3_wr");
    csr_write(19'h7FF67, 8'h00, "ader0_b2_wr");
    csr_write(19'h7FF6B, 8'h00, "ader0_b1_wr");
    csr_write(19'h7FF6F, 8'h24, "ader0_b0_wr");
    m_ader[0] = {f0_base, 16'h0000, 8'h24};

    // Node CPU CSR write and read through function 1.
    ack_delay = $urandom_range(0, 3);
    fn_access(32'h00CD0000, 6'h39, 1'b1, 32'h12345678, 1'b0, 2'b00, "cpu_wr");
    chk("cpu_wr_adr", 32'(last_adr), 32'h00334000);
    chk("cpu_wr_dat", last_dat, 32'h12345678);
    ack_delay = 0;
    slave_rdata = 32'hCAFEF00D;
    fn_access(32'h00CD0004, 6'h39, 1'b0, 32'h0, 1'b0, 2'b00, "cpu_rd");

    // Randomized mix of hits and misses across both functions.
    for (int i = 0; i < 24; i++) begin
      a = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 1) == 1) a[31:24] = f0_base;
      if ($urandom_range(0, 1) == 1) a[23:22] = 2'b11;
      case ($urandom_range(0, 3))
        0:       am = 6'h39;
        1:       am = 6'h09;
        2:       am = 6'h3D;
        default: am = 6'h39;
      endcase
      wr = ($urandom_range(0, 1) == 1);
      slave_rdata = $urandom;
      ack_delay = $urandom_range(0, 5);
      fn_access(a, am, wr, $urandom, 1'b0, 2'b00, "rnd");
    end

    // Silent Wishbone slave.
    ack_delay = 100000;
    fn_access(32'h00CD0008, 6'h39, 1'b0, 32'h0, 1'b0, 2'b00, "tmo_rd");
    fn_access(32'h00CD000C, 6'h39, 1'b1, 32'h5A5A5A5A, 1'b0, 2'b00, "tmo_wr");
    ack_delay = 0;

    // Misses: D16 transfer, out-of-window, disabled module, disabled function.
    fn_access(32'h00CD0000, 6'h39, 1'b0, 32'h0, 1'b1, 2'b00, "d16_miss");
    fn_access(32'h00800000, 6'h39, 1'b0, 32'h0, 1'b0, 2'b00, "win_miss");
    csr_write(19'h7FFF7, 8'h10, "disable");
    m_bits = m_bits & ~8'h10;
    fn_access(32'h00CD0000, 6'h39, 1'b1, 32'h11111111, 1'b0, 2'b00, "dis_miss");
    csr_write(19'h7FFFB, 8'h10, "reenable");
    m_bits = m_bits | 8'h10;
    csr_write(19'h7FF7F, 8'h01, "ader1_off");
    m_ader[1][7:0] = 8'h01;
    fn_access(32'h00CD0000, 6'h39, 1'b0, 32'h0, 1'b0, 2'b00, "fdis_miss");
    csr_write(19'h7FF7F, 8'hE4, "ader1_on");
    m_ader[1][7:0] = 8'hE4;
    slave_rdata = $urandom;
    fn_access(32'h00CD0010, 6'h39, 1'b0, 32'h0, 1'b0, 2'b00, "fen_hit");

    // Board sits in slot 7; CR/CSR of slot 8 must not answer.
    vme_ga_n_i = ~5'd7;
    csr_access(19'h0001F, 1'b0, 8'h00, ack, rv, lat);
    chk("wrong_slot", 32'(ack), 32'd0);
    vme_ga_n_i = ~5'd8;

    // Asynchronous reset while DTACK is being driven.
    badr = {8'h00, csr_slot, 19'h0001F};
    @(negedge clk_i);
    vme_addr_i    = badr[31:1];
    vme_am_i      = 6'h2F;
    vme_lword_n_i = 1'b1;
    vme_write_n_i = 1'b1;
    vme_as_n_i    = 1'b0;
    @(negedge clk_i);
    vme_ds_n_i = 2'b10;
    repeat (5) @(negedge clk_i);
    chk("mid_dtack_on", 32'(vme_dtack_n_o), 32'd0);
    #1 rst_a_i = 1'b1;
    #1;
    chk("mid_dtack_oe", 32'(vme_dtack_oe_o), 32'd0);
    chk("mid_dtack_n", 32'(vme_dtack_n_o), 32'd1);
    chk("mid_data_oe", 32'(vme_data_oe_o), 32'd0);
    chk("mid_data", vme_data_o, 32'h0);
    vme_ds_n_i = 2'b11;
    vme_as_n_i = 1'b1;
    @(negedge clk_i);
    rst_a_i = 1'b0;
    m_bits = '0; m_user = '0; m_ader[0] = 32'h1; m_ader[1] = 32'h1;
    @(negedge clk_i);
    chk("post_rst_en", 32'(module_en_o), 32'(m_bits[4]));
    csr_read(19'h7FF7F, m_ader[1][7:0], "post_rst_ader1");
    csr_read(19'h7FF33, m_user, "post_rst_user");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
